// File: rtl/spi_transaction_arbiter_pkg.sv
// Shared types for the SPI transaction arbiter: FSM state encoding and
// the width of the WAIT/GAP cycle counter.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        RESP   = 3'd3,
        REJECT = 3'd4,
        GAP    = 3'd5
    } arb_state_t;

    // One counter serves both WAIT timeout and GAP; sized for up to 65536 cycles.
    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/spi_transaction_arbiter_rr_arbiter.sv
// Combinational round-robin picker: scans requests starting at ptr_i and
// returns the first asserted one as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] cand_s;
    logic          hit_s;

    // Priority scan from the pointer, wrapping modulo N.
    always_comb begin
        gnt_o  = '0;
        idx_o  = '0;
        any_o  = 1'b0;
        cand_s = '0;
        hit_s  = 1'b0;
        for (int off = 0; off < int'(N); off++) begin
            cand_s        = IW'((32'(ptr_i) + 32'(off)) % N);
            hit_s         = !any_o && req_i[cand_s];
            gnt_o[cand_s] = gnt_o[cand_s] | hit_s;
            idx_o         = hit_s ? cand_s : idx_o;
            any_o         = any_o | hit_s;
        end
    end

endmodule

// File: rtl/spi_transaction_arbiter.sv
// Shares one half-duplex SPI engine between NUM_REQ requesters: round-robin
// grant, one-cycle issue, bounded wait for completion, response, then a CS gap.
module spi_transaction_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ               = 4,
    parameter int unsigned DATA_WIDTH            = 32,
    parameter int unsigned TRANSACTION_LEN_WIDTH = 8,
    parameter int unsigned TIMEOUT_CYCLES        = 4096,
    parameter int unsigned GAP_CYCLES            = 4
) (
    input  logic                                       fabric_clk,
    input  logic                                       reset,
    input  logic [NUM_REQ-1:0]                         req_valid,
    output logic [NUM_REQ-1:0]                         req_ready,
    input  logic [NUM_REQ*TRANSACTION_LEN_WIDTH-1:0]   req_length,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]              req_data,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]              req_mask,
    output logic [NUM_REQ-1:0]                         resp_valid,
    output logic [DATA_WIDTH-1:0]                      resp_data,
    output logic                                       resp_error,
    output logic [TRANSACTION_LEN_WIDTH-1:0]           transaction_length,
    output logic [DATA_WIDTH-1:0]                      transaction_data,
    output logic [DATA_WIDTH-1:0]                      transaction_rw_mask,
    input  logic [DATA_WIDTH-1:0]                      transaction_read_data,
    input  logic                                       spi_done,
    output logic                                       busy,
    output logic [$clog2(NUM_REQ)-1:0]                 grant_id
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned LW    = TRANSACTION_LEN_WIDTH;

    // Bits at or above the transaction length never came off the wire.
    function automatic logic [DATA_WIDTH-1:0] len_mask(input logic [LW-1:0] len);
        logic [DATA_WIDTH-1:0] m;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            m[i] = (32'(i) < 32'(len));
        end
        return m;
    endfunction

    arb_state_t              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        grant_id_q, grant_id_d;
    logic [LW-1:0]           len_q, len_d;
    logic [LW-1:0]           tlen_q, tlen_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic [DATA_WIDTH-1:0]   tmask_q, tmask_d;
    logic [NUM_REQ-1:0]      resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
    logic                    resp_error_q, resp_error_d;
    logic                    busy_q, busy_d;

    logic [NUM_REQ-1:0]      win_gnt_s;
    logic [IDX_W-1:0]        win_idx_s;
    logic                    win_any_s;
    logic [LW-1:0]           win_len_s;
    logic [DATA_WIDTH-1:0]   win_data_s;
    logic [DATA_WIDTH-1:0]   win_mask_s;
    logic                    win_illegal_s;
    logic [NUM_REQ-1:0]      grant_oh_s;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (win_gnt_s),
        .idx_o (win_idx_s),
        .any_o (win_any_s)
    );

    // Mux the winner's request fields using the one-hot grant.
    always_comb begin
        win_len_s  = '0;
        win_data_s = '0;
        win_mask_s = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            win_len_s  = win_len_s  | (req_length[i*LW +: LW]               & {LW{win_gnt_s[i]}});
            win_data_s = win_data_s | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{win_gnt_s[i]}});
            win_mask_s = win_mask_s | (req_mask[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{win_gnt_s[i]}});
        end
    end

    assign win_illegal_s = (win_len_s == '0) || (32'(win_len_s) > 32'(DATA_WIDTH));
    assign grant_oh_s    = NUM_REQ'(1) << grant_id_q;
    assign req_ready     = (state_q == IDLE && !reset) ? win_gnt_s : '0;

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        len_d        = len_q;
        tlen_d       = '0;
        tdata_d      = tdata_q;
        tmask_d      = tmask_q;
        resp_valid_d = '0;
        resp_data_d  = '0;
        resp_error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_any_s) begin
                    grant_id_d = win_idx_s;
                    rr_ptr_d   = (win_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_s + IDX_W'(1);
                    len_d      = win_len_s;
                    if (win_illegal_s) begin
                        state_d      = REJECT;
                        resp_valid_d = win_gnt_s;
                        resp_error_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        tlen_d  = win_len_s;
                        tdata_d = win_data_s;
                        tmask_d = win_mask_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                // Completion beats a coincident timeout.
                if (spi_done) begin
                    state_d      = RESP;
                    resp_valid_d = grant_oh_s;
                    resp_data_d  = transaction_read_data & len_mask(len_q);
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = RESP;
                    resp_valid_d = grant_oh_s;
                    resp_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = GAP;
                cnt_d   = '0;
            end
            REJECT: begin
                state_d = GAP;
                cnt_d   = '0;
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge fabric_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            len_q        <= '0;
            tlen_q       <= '0;
            tdata_q      <= '0;
            tmask_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            len_q        <= len_d;
            tlen_q       <= tlen_d;
            tdata_q      <= tdata_d;
            tmask_q      <= tmask_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
            busy_q       <= busy_d;
        end
    end

    assign transaction_length  = tlen_q;
    assign transaction_data    = tdata_q;
    assign transaction_rw_mask = tmask_q;
    assign resp_valid          = resp_valid_q;
    assign resp_data           = resp_data_q;
    assign resp_error          = resp_error_q;
    assign busy                = busy_q;
    assign grant_id            = grant_id_q;

endmodule

// File: tb/tb_spi_transaction_arbiter.sv
// Directed bench for spi_transaction_arbiter: reset, round-robin fairness,
// a vector table of single transactions, and reset-during-WAIT.
module tb_spi_transaction_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int TO = 16;
    localparam int GP = 4;

    logic             fabric_clk = 1'b0;
    logic             reset = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [NR*LW-1:0] req_length = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR*DW-1:0] req_mask = '0;
    logic [NR-1:0]    resp_valid;
    logic [DW-1:0]    resp_data;
    logic             resp_error;
    logic [LW-1:0]    transaction_length;
    logic [DW-1:0]    transaction_data;
    logic [DW-1:0]    transaction_rw_mask;
    logic [DW-1:0]    transaction_read_data = '0;
    logic             spi_done = 1'b0;
    logic             busy;
    logic [1:0]       grant_id;

    spi_transaction_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .TRANSACTION_LEN_WIDTH(LW),
        .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GP)
    ) dut (
        .fabric_clk(fabric_clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_length(req_length), .req_data(req_data), .req_mask(req_mask),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
        .transaction_length(transaction_length), .transaction_data(transaction_data),
        .transaction_rw_mask(transaction_rw_mask),
        .transaction_read_data(transaction_read_data), .spi_done(spi_done),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 fabric_clk = ~fabric_clk;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        int          id;
        logic [7:0]  len;
        logic [31:0] data;
        logic [31:0] mask;
        logic [31:0] rd;
        int          delay;   // cycles in WAIT before spi_done; 0 = never
        bit          rej;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge fabric_clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 40) begin
            step();
            k++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic do_txn(input vec_t v);
        logic [NR-1:0] oh;
        bit            got;
        bit            bad_tl;
        int            k;
        oh  = 4'd1 << v.id;
        got = 1'b0;
        req_length[v.id*LW +: LW] = v.len;
        req_data[v.id*DW +: DW]   = v.data;
        req_mask[v.id*DW +: DW]   = v.mask;
        req_valid[v.id]           = 1'b1;
        transaction_read_data     = v.rd;
        for (k = 0; k < 50 && !got; k++) begin
            #2;
            if (req_ready != '0) got = 1'b1;
            else begin
                @(posedge fabric_clk);
                #1;
            end
        end
        chk("accept_seen", 32'(got), 32'd1);
        chk("ready_onehot", 32'(req_ready), 32'(oh));
        step();
        req_valid[v.id] = 1'b0;
        if (v.rej) begin
            chk("rej_len", 32'(transaction_length), 32'd0);
            chk("rej_valid", 32'(resp_valid), 32'(oh));
            chk("rej_err", 32'(resp_error), 32'd1);
            chk("rej_data", resp_data, 32'd0);
            bad_tl = 1'b0;
            k = 0;
            while ((busy || k == 0) && k < 40) begin
                step();
                if (transaction_length != '0) bad_tl = 1'b1;
                k++;
            end
            chk("rej_len_stays_zero", 32'(bad_tl), 32'd0);
            chk("rej_idle", 32'(busy), 32'd0);
        end else begin
            chk("issue_len", 32'(transaction_length), 32'(v.len));
            chk("issue_gid", 32'(grant_id), 32'(v.id));
            chk("issue_data", transaction_data, v.data);
            chk("issue_mask", transaction_rw_mask, v.mask);
            step();
            chk("len_one_cycle", 32'(transaction_length), 32'd0);
            if (v.delay == 0) begin
                k = 0;
                while (resp_valid == '0 && k < 40) begin
                    step();
                    k++;
                end
                chk("timeout_cycles", 32'(k), 32'(TO));
            end else begin
                repeat (v.delay - 1) step();
                chk("no_early_resp", 32'(resp_valid), 32'd0);
                chk("mask_held", transaction_rw_mask, v.mask);
                spi_done = 1'b1;
                step();
                spi_done = 1'b0;
            end
            chk("resp_valid", 32'(resp_valid), 32'(oh));
            chk("resp_data", resp_data, v.exp_data);
            chk("resp_err", 32'(resp_error), 32'(v.exp_err));
            step();
            chk("resp_single", 32'(resp_valid), 32'd0);
            wait_idle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  ngr;
        int  last;
        bit  pend;

        vecs[0] = '{32'd1, 8'd8,  32'hA500_0000, 32'hFF00_0000, 32'h1234_56AB, 32'd10, 1'b0, 32'h0000_00AB, 1'b0};
        vecs[1] = '{32'd2, 8'd16, 32'h0000_A5A5, 32'hFF00_0000, 32'h1234_5678, 32'd4,  1'b0, 32'h0000_5678, 1'b0};
        vecs[2] = '{32'd3, 8'd32, 32'hDEAD_BEEF, 32'h0000_0000, 32'hCAFE_F00D, 32'd1,  1'b0, 32'hCAFE_F00D, 1'b0};
        vecs[3] = '{32'd0, 8'd1,  32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF, 32'd3,  1'b0, 32'h0000_0001, 1'b0};
        vecs[4] = '{32'd2, 8'd5,  32'h0000_0015, 32'h0000_001F, 32'hFFFF_FFFF, 32'd0,  1'b0, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'd1, 8'd20, 32'h0001_2345, 32'h000F_0000, 32'hABCD_EF12, 32'd16, 1'b0, 32'h000D_EF12, 1'b0};
        vecs[6] = '{32'd0, 8'd0,  32'h1111_1111, 32'hFFFF_FFFF, 32'h0000_0000, 32'd0,  1'b1, 32'h0000_0000, 1'b1};
        vecs[7] = '{32'd3, 8'd33, 32'h2222_2222, 32'hFFFF_FFFF, 32'h0000_0000, 32'd0,  1'b1, 32'h0000_0000, 1'b1};

        // Reset with requests and spurious done pulses present.
        reset      = 1'b1;
        req_valid  = 4'hF;
        req_length = {8'd8, 8'd8, 8'd8, 8'd8};
        spi_done   = 1'b1;
        repeat (3) step();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_len", 32'(transaction_length), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_data", resp_data, 32'd0);
        chk("rst_tdata", transaction_data, 32'd0);
        spi_done = 1'b0;
        reset    = 1'b0;

        // All four requesters continuously valid for eight grants.
        ngr  = 0;
        last = 0;
        pend = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            spi_done = pend;
            pend     = (transaction_length != '0);
            if (ngr == 8) req_valid = '0;
            #2;
            if (ngr < 8 && req_ready != '0) begin
                chk("rr_order", 32'(req_ready), 32'(4'd1 << (ngr % 4)));
                if (ngr > 0) chk("accept_spacing", 32'(cyc - last), 32'(4 + GP));
                last = cyc;
                ngr++;
            end
            if (ngr == 8 && req_valid == '0 && !busy && !pend && !spi_done) break;
            @(posedge fabric_clk);
            #1;
        end
        spi_done = 1'b0;
        chk("fair_grants", 32'(ngr), 32'd8);
        chk("fair_idle", 32'(busy), 32'd0);
        step();

        foreach (vecs[i]) do_txn(vecs[i]);

        // spi_done while idle must not start anything.
        spi_done = 1'b1;
        step();
        spi_done = 1'b0;
        chk("stray_done_busy", 32'(busy), 32'd0);
        chk("stray_done_resp", 32'(resp_valid), 32'd0);

        // Reset while waiting on the engine, then a late done pulse.
        req_length[2*LW +: LW] = 8'd8;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        step();
        chk("wrst_busy", 32'(busy), 32'd0);
        chk("wrst_gid", 32'(grant_id), 32'd0);
        chk("wrst_tdata", transaction_data, 32'd0);
        chk("wrst_tmask", transaction_rw_mask, 32'd0);
        reset    = 1'b0;
        spi_done = 1'b1;
        step();
        spi_done = 1'b0;
        chk("late_done_resp", 32'(resp_valid), 32'd0);
        chk("late_done_busy", 32'(busy), 32'd0);
        step();
        chk("late_done_resp2", 32'(resp_valid), 32'd0);
        req_valid = 4'hF;
        #2;
        chk("post_rst_first_grant", 32'(req_ready), 32'd1);
        step();
        req_valid = '0;
        chk("post_rst_gid", 32'(grant_id), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
